// File: rtl/alu_issue_ctrl_if.sv
// Opcode constants shared by the issue controller and its ALU, plus the
// handshake/ALU bus interface.
// slave  = issue controller side (accepts instructions, drives the ALU)
// master = front end / ALU side
package alu_issue_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_LSH  = 4'd6;
  localparam logic [3:0] OP_RSH  = 4'd7;
  localparam logic [3:0] OP_ARSH = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_FMUL = 4'd10;
  localparam logic [3:0] OP_CMP  = 4'd11;
  localparam logic [3:0] OP_CMPR = 4'd12;
  // 13..15 are unassigned and retire as illegal
endpackage

interface alu_issue_ctrl_if #(parameter int WIDTH = 16);
  logic             instr_valid;
  logic             instr_ready;
  logic [3:0]       instr_op;
  logic [3:0]       instr_rdest;
  logic [3:0]       instr_rsrc;
  logic             instr_imm_en;
  logic [WIDTH-1:0] instr_imm;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_opcode;
  logic [WIDTH-1:0] alu_c;
  logic [WIDTH-1:0] alu_d;
  logic             alu_low;
  logic             alu_neg;
  logic             alu_zero;

  modport slave (
    input  instr_valid, instr_op, instr_rdest, instr_rsrc, instr_imm_en, instr_imm,
    output instr_ready,
    output alu_a, alu_b, alu_opcode,
    input  alu_c, alu_d, alu_low, alu_neg, alu_zero
  );

  modport master (
    output instr_valid, instr_op, instr_rdest, instr_rsrc, instr_imm_en, instr_imm,
    input  instr_ready,
    input  alu_a, alu_b, alu_opcode,
    output alu_c, alu_d, alu_low, alu_neg, alu_zero
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue sequencer in front of a combinational ALU.
// IDLE -> OPER -> WB -> IDLE; one instruction per 3 cycles. Operands are read
// from a 16x16 register file at acceptance, ALU results are captured at the
// end of OPER and committed (regs + psr) at the end of WB.
// Optional: define ISSUE_PERF_CNT_EN to add the retired_count output.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_issue_ctrl_if.slave  bus,
  output logic             psr_low,
  output logic             psr_neg,
  output logic             psr_zero,
  output logic             wb_done,
  output logic             illegal_op,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [15:0]      retired_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_OPER, S_WB} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]       alu_opcode_q, alu_opcode_d;
  logic [3:0]       rdest_q, rdest_d;
  logic [WIDTH-1:0] c_q, c_d, d_q, d_d;
  logic             flow_q, flow_d, fneg_q, fneg_d, fzero_q, fzero_d;
  logic             psr_low_q, psr_low_d, psr_neg_q, psr_neg_d, psr_zero_q, psr_zero_d;
  logic             wb_done_q, wb_done_d, illegal_q, illegal_d;
`ifdef ISSUE_PERF_CNT_EN
  logic [15:0]      cnt_q, cnt_d;
`endif

  logic [WIDTH-1:0] src;
  logic             is_shift;
  logic             op_legal;
  logic [3:0]       rdest_hi;

  assign src      = bus.instr_imm_en ? bus.instr_imm : regs_q[bus.instr_rsrc];
  assign is_shift = (bus.instr_op == OP_LSH) || (bus.instr_op == OP_RSH) ||
                    (bus.instr_op == OP_ARSH);
  assign op_legal = (alu_opcode_q <= OP_CMPR);
  assign rdest_hi = rdest_q + 4'd1;  // 4-bit wrap: rdest 15 pairs with R0

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_opcode  = alu_opcode_q;
  assign psr_low         = psr_low_q;
  assign psr_neg         = psr_neg_q;
  assign psr_zero        = psr_zero_q;
  assign wb_done         = wb_done_q;
  assign illegal_op      = illegal_q;
  assign dbg_data        = regs_q[dbg_addr];
`ifdef ISSUE_PERF_CNT_EN
  assign retired_count   = cnt_q;
`endif

  // Next-state: accept in IDLE, capture ALU outputs in OPER, commit in WB
  always_comb begin
    state_d      = state_q;
    regs_d       = regs_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_opcode_d = alu_opcode_q;
    rdest_d      = rdest_q;
    c_d          = c_q;
    d_d          = d_q;
    flow_d       = flow_q;
    fneg_d       = fneg_q;
    fzero_d      = fzero_q;
    psr_low_d    = psr_low_q;
    psr_neg_d    = psr_neg_q;
    psr_zero_d   = psr_zero_q;
    wb_done_d    = 1'b0;
    illegal_d    = 1'b0;
`ifdef ISSUE_PERF_CNT_EN
    cnt_d        = wb_done_q ? cnt_q + 16'd1 : cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          state_d      = S_OPER;
          alu_opcode_d = bus.instr_op;
          rdest_d      = bus.instr_rdest;
          // shifts take the amount on A and the value on B
          alu_a_d      = is_shift ? src : regs_q[bus.instr_rdest];
          alu_b_d      = is_shift ? regs_q[bus.instr_rdest] : src;
        end
      end
      S_OPER: begin
        state_d   = S_WB;
        c_d       = bus.alu_c;
        d_d       = bus.alu_d;
        flow_d    = bus.alu_low;
        fneg_d    = bus.alu_neg;
        fzero_d   = bus.alu_zero;
        wb_done_d = 1'b1;
        illegal_d = !op_legal;
      end
      S_WB: begin
        state_d = S_IDLE;
        if (op_legal) begin
          psr_low_d  = flow_q;
          psr_neg_d  = fneg_q;
          psr_zero_d = fzero_q;
        end
        case (alu_opcode_q)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
          OP_LSH, OP_RSH, OP_ARSH, OP_FMUL: regs_d[rdest_q] = c_q;
          OP_MUL: begin
            regs_d[rdest_q]  = c_q;
            regs_d[rdest_hi] = d_q;
          end
          default: ;  // CMP/CMPR and illegal ops write nothing
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      rdest_q      <= '0;
      c_q          <= '0;
      d_q          <= '0;
      flow_q       <= 1'b0;
      fneg_q       <= 1'b0;
      fzero_q      <= 1'b0;
      psr_low_q    <= 1'b0;
      psr_neg_q    <= 1'b0;
      psr_zero_q   <= 1'b0;
      wb_done_q    <= 1'b0;
      illegal_q    <= 1'b0;
`ifdef ISSUE_PERF_CNT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      regs_q       <= regs_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_opcode_q <= alu_opcode_d;
      rdest_q      <= rdest_d;
      c_q          <= c_d;
      d_q          <= d_d;
      flow_q       <= flow_d;
      fneg_q       <= fneg_d;
      fzero_q      <= fzero_d;
      psr_low_q    <= psr_low_d;
      psr_neg_q    <= psr_neg_d;
      psr_zero_q   <= psr_zero_d;
      wb_done_q    <= wb_done_d;
      illegal_q    <= illegal_d;
`ifdef ISSUE_PERF_CNT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Single-issue sequencer that drives the combinational ALU from the requester side. It accepts one register-to-register or register-immediate instruction per handshake and reads operands from an internal 16x16 register file. It presents opcode and operands on the ALU input ports, captures the ALU result/flag outputs, then writes back the result and the processor status flags. It sits between the instruction fetch/decode front end and the ALU.

Parameters:
NREGS, 16, number of general registers (fixed at 16; 4-bit register indices)
WIDTH, 16, datapath width in bits

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept (high only in IDLE)
instr_op  in  4  opcode, encoded with the shared opcode include constants
instr_rdest  in  4  destination / first operand register
instr_rsrc  in  4  source register
instr_imm_en  in  1  use instr_imm instead of R[rsrc]
instr_imm  in  16  immediate operand
alu_a  out  16  to ALU A
alu_b  out  16  to ALU B
alu_opcode  out  4  to ALU Opcode
alu_c  in  16  ALU result C
alu_d  in  16  ALU high result D (MUL only)
alu_low  in  1  ALU Low flag
alu_neg  in  1  ALU Negative flag
alu_zero  in  1  ALU Zero flag
psr_low  out  1  committed Low flag
psr_neg  out  1  committed Negative flag
psr_zero  out  1  committed Zero flag
wb_done  out  1  one-cycle pulse when an instruction retires
illegal_op  out  1  one-cycle pulse, coincident with wb_done, for an unrecognised opcode
dbg_addr  in  4  debug register read index
dbg_data  out  16  R[dbg_addr], combinational read

Behaviour:
- Reset, with reset high at a clock edge:
  - state goes to IDLE; R0..R15 and all psr_* are cleared to 0.
  - alu_a, alu_b and alu_opcode are cleared to 0; wb_done and illegal_op are 0.
  - Reset aborts any in-flight instruction with no writeback. Reset wins over a simultaneous handshake.
- States: IDLE -> OPER -> WB -> IDLE; no other transitions.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready at edge T, latch op, rdest and the operands, then go to OPER.
- Operand selection:
  - src = instr_imm_en ? instr_imm : R[rsrc].
  - For LSH, RSH and ARSH: alu_a=src (shift amount), alu_b=R[rdest] (value).
  - For all other ops: alu_a=R[rdest], alu_b=src.
  - NOT ignores alu_b.
  - Registers are read at acceptance, so R[rdest]==R[rsrc] aliasing is legal.
- OPER (cycle T+1):
  - alu_* outputs are registered and held stable for the whole cycle.
  - At the end of T+1, alu_c, alu_d and the three flags are captured into internal holding registers. Go to WB.
- WB (cycle T+2), commit at the end of the cycle:
  - ADD, SUB, AND, OR, XOR, NOT, LSH, RSH, ARSH, FMUL: R[rdest] <= C.
  - MUL: R[rdest] <= C and R[(rdest+1) mod 16] <= D. rdest=15 wraps the D write to R0.
  - CMP, CMPR: no register write.
  - All recognised ops: psr_low/neg/zero <= captured flags.
  - Unrecognised opcode: no register write, psr unchanged, illegal_op=1.
  - wb_done=1 during WB. Next state is IDLE.
- Timing: instr_ready is low for T+1 and T+2, so throughput is one instruction per 3 cycles. A result is visible on dbg_data and to the next instruction from T+3.
- alu_* outputs hold their last value in IDLE and WB.
- dbg_data reads the register file combinationally. During WB it shows the pre-commit value.

Optional Feature:
ISSUE_PERF_CNT_EN:
- Defined:
  - Adds output retired_count [15:0], cleared by reset.
  - Increments by 1 on every wb_done, including illegal ops.
  - Wraps 0xFFFF -> 0x0000.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then R1=0x0005 and R2=0x0003 via immediate ADDs to zeroed regs; ADD rdest=1 rsrc=2 -> alu_a=5, alu_b=3 in OPER; R1=0x0008; psr_zero=0; wb_done pulses at T+2; instr_ready is 0 at T+1 and T+2.
- R3=0x0004, imm=2, LSH rdest=3 imm_en -> alu_a=2, alu_b=4; R3=0x0010.
- R15=0x7FFF, imm=2, MUL rdest=15 -> R15=0xFFFE, R0=0x0000 (wrap of the D write).
- CMP with R4=R5=0x1234 -> psr_zero=1; R4 and R5 unchanged.
- Unused opcode -> illegal_op and wb_done pulse together; registers and psr unchanged; retired_count increments when ISSUE_PERF_CNT_EN is defined.
- Assert reset during OPER of ADD R1 -> no writeback, R1=0, state IDLE, instr_ready=1 on the next cycle; instr_valid held high with reset is not accepted.
